// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Instruction memory for the fetch stage of a pipelined CPU, with a built-in
//   byte-serial boot loader.
//
//   Loader:
//     The loader writes program bytes in ascending byte-address order. Each
//     word is big-endian, so byte address 4*w+0 lands in bits [31:24] of word w.
//     When the last byte of the array has been written, the memory becomes
//     READY and load_done pulses for one cycle.
//
//   Fetch port:
//     Fetch has one cycle of registered latency. A stall holds the previous
//     result. Any cycle that does not produce an instruction returns NOP_WORD,
//     which encodes ADD $0,$0,$0.
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   load_start   in   1       begin or restart a program load
//   load_valid   in   1       load_byte is valid this cycle
//   load_byte    in   8       program byte, in ascending byte-address order
//   load_done    out  1       one-cycle pulse when the last byte is written
//   ready        out  1       memory fully loaded; fetch enabled
//   fetch_en     in   1       issue a fetch at pc this cycle
//   stall        in   1       hold the fetch outputs
//   pc           in   ADDR_W  fetch byte address
//   instr        out  32      fetched instruction (NOP_WORD when none)
//   instr_valid  out  1       instr/fault are meaningful
//   fault        out  2       00 ok, 01 misaligned, 10 out of range
// ---------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_done,
  output logic              ready,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [1:0]        fault
);

  localparam int unsigned BYTES   = DEPTH_WORDS * 4;
  localparam int unsigned CNT_W   = $clog2(BYTES);
  localparam int unsigned WORD_AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               byte_wr;
  logic               last_byte;
  logic               misaligned;
  logic               out_of_range;
  logic               fetch_go;
  logic [WORD_AW-1:0] wr_word;
  logic [WORD_AW-1:0] rd_word;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a value on every path,
  // so no latch can be inferred.
  always_comb begin
    // A load_start in LOAD restarts the load. Any byte presented in that same
    // cycle is dropped, including the final byte.
    byte_wr      = (state == ST_LOAD) && load_valid && !load_start;
    // DEPTH_WORDS is a power of two, so the last byte address is all ones.
    last_byte    = &cnt;
    wr_word      = cnt[CNT_W-1:2];
    rd_word      = pc[WORD_AW+1:2];
    misaligned   = |pc[1:0];
    // Any set bit above the word index is out of range. The full PC width is
    // compared, so addresses never alias onto the array.
    out_of_range = |pc[ADDR_W-1:WORD_AW+2];
    // A load request in READY takes precedence over a fetch in the same cycle.
    fetch_go     = (state == ST_READY) && fetch_en && !load_start;
  end

  // -------------------------------------------------------------------------
  // Loader FSM and byte counter
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      cnt       <= '0;
      ready     <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        // Start from EMPTY or READY, or restart in the middle of a load.
        state <= ST_LOAD;
        cnt   <= '0;
        ready <= 1'b0;
      end else if (byte_wr) begin
        // The counter wraps to zero on the last byte.
        cnt <= cnt + CNT_W'(1);
        if (last_byte) begin
          state     <= ST_READY;
          ready     <= 1'b1;
          load_done <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Memory array: big-endian byte-lane writes
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset. Clearing it would prevent RAM inference,
  // and READY (which gates every read) is only reached after a full reload.
  always_ff @(posedge clk) begin
    if (byte_wr) begin
      case (cnt[1:0])
        2'd0:    mem[wr_word][31:24] <= load_byte;
        2'd1:    mem[wr_word][23:16] <= load_byte;
        2'd2:    mem[wr_word][15:8]  <= load_byte;
        default: mem[wr_word][7:0]   <= load_byte;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Fetch port: registered outputs, stall holds, misaligned beats range
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      fault       <= FAULT_OK;
    end else if (!stall) begin
      if (!fetch_go) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b0;
        fault       <= FAULT_OK;
      end else if (misaligned) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b1;
        fault       <= FAULT_MISALIGN;
      end else if (out_of_range) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b1;
        fault       <= FAULT_RANGE;
      end else begin
        instr       <= mem[rd_word];
        instr_valid <= 1'b1;
        fault       <= FAULT_OK;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//   Scoreboard bench for instr_mem_loader (DEPTH_WORDS=64).
//
//   Model:
//     A byte-array model runs on every rising edge. It looks at the same inputs
//     the DUT sees and pushes the expected registered outputs into a queue.
//
//   Monitor:
//     A monitor pops one expected entry at each falling edge and compares it
//     with the DUT outputs.
//
//   Directed checks:
//     Directed checks cover asynchronous reset values, the first fetched word,
//     stall hold and the load cycle counts.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NBYTES = DEPTH * 4;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_done;
  logic        ready;
  logic        fetch_en = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  fault;

  instr_mem_loader #(
    .ADDR_W(32),
    .DEPTH_WORDS(DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_byte(load_byte),
    .load_done(load_done),
    .ready(ready),
    .fetch_en(fetch_en),
    .stall(stall),
    .pc(pc),
    .instr(instr),
    .instr_valid(instr_valid),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  fault;
    logic        ready;
    logic        done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_img [NBYTES];
  bit         m_loaded;
  bit         m_loading;
  int         m_cnt;
  exp_t       m_out;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_loaded  = 1'b0;
        m_loading = 1'b0;
        m_cnt     = 0;
        m_out     = '{instr: NOP, valid: 1'b0, fault: 2'b00, ready: 1'b0, done: 1'b0};
        exp_q.delete();
      end else begin
        // Fetch result, computed from the state before this edge.
        if (!stall) begin
          if (m_loaded && fetch_en && !load_start) begin
            if (pc % 4 != 0) begin
              m_out.instr = NOP; m_out.valid = 1'b1; m_out.fault = 2'b01;
            end else if (pc / 4 >= DEPTH) begin
              m_out.instr = NOP; m_out.valid = 1'b1; m_out.fault = 2'b10;
            end else begin
              m_out.instr = {m_img[pc], m_img[pc+1], m_img[pc+2], m_img[pc+3]};
              m_out.valid = 1'b1; m_out.fault = 2'b00;
            end
          end else begin
            m_out.instr = NOP; m_out.valid = 1'b0; m_out.fault = 2'b00;
          end
        end

        // Loader.
        m_out.done = 1'b0;
        if (load_start) begin
          m_loaded = 1'b0; m_loading = 1'b1; m_cnt = 0;
        end else if (m_loading && load_valid) begin
          m_img[m_cnt] = load_byte;
          if (m_cnt == NBYTES - 1) begin
            m_loading = 1'b0; m_loaded = 1'b1; m_cnt = 0; m_out.done = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        m_out.ready = m_loaded;
        exp_q.push_back(m_out);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_valid", {31'd0, instr_valid}, {31'd0, e.valid});
        check("sb_fault", {30'd0, fault}, {30'd0, e.fault});
        check("sb_ready", {31'd0, ready}, {31'd0, e.ready});
        check("sb_load_done", {31'd0, load_done}, {31'd0, e.done});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [7:0] prog [NBYTES];

  task automatic idle(input int n);
    fetch_en = 1'b0; stall = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_fault"}, {30'd0, fault}, 32'd0);
  endtask

  // Assert reset between clock edges and check the outputs before any edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks(tag);
    fetch_en = 1'b0; stall = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Start a load and send prog[]. The start cycle also presents a byte, which
  // must be dropped. Returns the cycles from the first post-start edge to
  // load_done.
  task automatic load_image(input bit gaps, output int cycles);
    int  idx;
    bit  seen;
    load_start = 1'b1; load_valid = 1'b1; load_byte = 8'hEE; fetch_en = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    idx = 0; cycles = 0; seen = 1'b0;
    while (!seen && cycles < 1200) begin
      cycles++;
      if ((gaps && (cycles % 2 == 1)) || idx >= NBYTES) begin
        load_valid = 1'b0;
      end else begin
        load_valid = 1'b1; load_byte = prog[idx]; idx++;
      end
      @(negedge clk);
      if (load_done) seen = 1'b1;
    end
    load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input bit en, input bit st);
    pc = a; fetch_en = en; stall = st;
    @(negedge clk);
  endtask

  task automatic fetch_all_words();
    for (int w = 0; w < DEPTH; w++) fetch(32'(w * 4), 1'b1, 1'b0);
    fetch_en = 1'b0;
  endtask

  task automatic random_prog();
    for (int i = 0; i < NBYTES; i++) prog[i] = 8'($urandom);
  endtask

  initial begin
    int          cyc;
    logic [31:0] word1;
    logic [31:0] rpc;

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1 reset_checks("rst_init");
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Fetch before any load: expect NOP with valid=0.
    fetch(32'h0, 1'b1, 1'b0);
    fetch(32'h4, 1'b1, 1'b0);

    // Gap-free load with the known first word.
    random_prog();
    prog[0] = 8'h8C; prog[1] = 8'h10; prog[2] = 8'h00; prog[3] = 8'h00;
    load_image(1'b0, cyc);
    check("load_cycles_nogap", 32'(cyc), 32'(NBYTES));
    idle(1);
    fetch(32'h0, 1'b1, 1'b0);
    check("word0_direct", instr, 32'h8C10_0000);

    // Fault cases.
    fetch(32'd2, 1'b1, 1'b0);
    fetch(32'd256, 1'b1, 1'b0);
    fetch(32'd257, 1'b1, 1'b0);
    fetch(32'hFFFF_FFFC, 1'b1, 1'b0);

    // Stall hold after a fetch of word 1.
    word1 = {prog[4], prog[5], prog[6], prog[7]};
    fetch(32'd4, 1'b1, 1'b0);
    check("stall_pre", instr, word1);
    for (int k = 0; k < 3; k++) begin
      fetch(32'(8 + 4 * k), 1'b1, 1'b1);
      check("stall_hold", instr, word1);
    end
    fetch_all_words();

    // Randomized fetch traffic.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rpc = 32'($urandom_range(0, DEPTH - 1) * 4);
        6:       rpc = 32'($urandom_range(0, NBYTES - 1)) | 32'd1;
        7:       rpc = 32'($urandom_range(DEPTH, 4000) * 4);
        8:       rpc = 32'($urandom_range(NBYTES, 9000)) | 32'd2;
        default: rpc = $urandom;
      endcase
      fetch(rpc, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
    end
    idle(1);

    // Restart mid-load, then a full reload with a new image.
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      load_valid = 1'b1; load_byte = 8'($urandom); @(negedge clk);
    end
    random_prog();
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    load_image(1'b0, cyc);
    check("load_cycles_restart", 32'(cyc), 32'(NBYTES));
    fetch(32'h0, 1'b1, 1'b0);
    check("word0_reload", instr, 32'h2008_0005);
    fetch_all_words();

    // load_start in READY colliding with a fetch, then fetches while loading.
    pc = 32'h8; fetch_en = 1'b1; load_start = 1'b1; @(negedge clk);
    load_start = 1'b0;
    check("collide_ready", {31'd0, ready}, 32'd0);
    check("collide_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h0, 1'b1, 1'b0);
    fetch(32'h4, 1'b1, 1'b0);

    // Gapped reload of the same image; expect 512 cycles and the same words.
    load_image(1'b1, cyc);
    check("load_cycles_gap", 32'(cyc), 32'(2 * NBYTES));
    fetch_all_words();

    // load_start coinciding with the final byte: the byte is dropped and the
    // load restarts from address 0.
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    for (int i = 0; i < NBYTES - 1; i++) begin
      load_valid = 1'b1; load_byte = prog[i]; @(negedge clk);
    end
    load_valid = 1'b1; load_byte = 8'h5A; load_start = 1'b1; @(negedge clk);
    load_start = 1'b0;
    check("final_collide_ready", {31'd0, ready}, 32'd0);
    check("final_collide_done", {31'd0, load_done}, 32'd0);
    random_prog();
    for (int i = 0; i < NBYTES; i++) begin
      load_valid = 1'b1; load_byte = prog[i]; @(negedge clk);
    end
    load_valid = 1'b0;
    fetch_all_words();

    // Async reset while a valid instruction is on the outputs.
    fetch(32'h10, 1'b1, 1'b0);
    mid_reset("rst_mid_fetch");
    fetch(32'h10, 1'b1, 1'b0);

    // Async reset in the middle of a load; the partial image must not be
    // fetchable.
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      load_valid = 1'b1; load_byte = 8'($urandom); @(negedge clk);
    end
    mid_reset("rst_mid_load");
    fetch(32'h0, 1'b1, 1'b0);
    fetch(32'h4, 1'b1, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
